// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
// Shared types and constants for the CNN result transmitter.
//   tx_state_t     : transmit FSM state encoding
//   CNN_HDR_BYTE   : byte that opens every frame
//   CNN_RES_BITS   : result bits per frame (26x26 map)
//   bytes_for_bits : number of bytes needed to carry n bits
// Optional feature macro used by this slice: CNN_TX_CHECKSUM_EN
// ----------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4
  } tx_state_t;

  localparam logic [7:0] CNN_HDR_BYTE = 8'hA5;
  localparam int         CNN_RES_BITS = 676;

  function automatic int bytes_for_bits(input int n_bits);
    return (n_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/cnn_byte_fifo.sv
// ----------------------------------------------------------------------------
// cnn_byte_fifo
// Single-clock byte FIFO with show-ahead output (dout is the head entry).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, din    : write request and data (ignored when full unless a pop
//                  happens in the same cycle)
//   pop, dout    : read request (ignored when empty) and head data
//   count        : number of stored entries (0..DEPTH)
//   empty, full  : status flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module cnn_byte_fifo
  import cnn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a push against a full FIFO is
  // still accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cnn_result_tx.sv
// ----------------------------------------------------------------------------
// cnn_result_tx
// Packs a stream of CNN result bits into bytes (LSB first), buffers them in a
// small FIFO and hands them one at a time to a UART transmitter as a frame:
//   header byte, N_BYTES data bytes, [checksum byte].
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   frm_strt         : start-of-frame pulse (only honoured when idle)
//   bit_vld, bit_in  : result bit stream; accepted when bit_vld && bit_rdy
//   bit_rdy          : transmitter can take a bit this cycle
//   trmt, tx_data    : one-cycle transmit request and the byte to send
//   tx_done          : UART finished the outstanding byte
//   busy             : a frame is in progress
//   frm_done         : one-cycle pulse once the frame has been sent
// Configuration:
//   CNN_TX_CHECKSUM_EN defined   -> a modulo-256 sum of the data bytes is
//                                   appended (frame = N_BYTES+2 bytes)
//   CNN_TX_CHECKSUM_EN undefined -> no checksum (frame = N_BYTES+1 bytes)
// ----------------------------------------------------------------------------
module cnn_result_tx
  import cnn_pkg::*;
#(
  parameter int         N_BITS     = CNN_RES_BITS,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] HDR_BYTE   = CNN_HDR_BYTE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frm_strt,
  input  logic       bit_vld,
  input  logic       bit_in,
  output logic       bit_rdy,
  output logic       trmt,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       frm_done
);

  localparam int N_BYTES = bytes_for_bits(N_BITS);
  localparam int BW      = $clog2(N_BITS + 1);
  localparam int YW      = $clog2(N_BYTES + 1);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);
  localparam logic [BW-1:0] BIT_END   = BW'(N_BITS);
  localparam logic [YW-1:0] BYTE_LAST = YW'(N_BYTES - 1);
  // A completed byte reaches the FIFO one cycle after its last bit, and one
  // more bit may be accepted in that cycle. Stopping at DEPTH-2 keeps one
  // slot in reserve for that in-flight byte, so nothing is ever dropped.
  localparam logic [CW-1:0] RDY_LIMIT = CW'(FIFO_DEPTH - 2);

  // FSM and transmit-side state
  tx_state_t       state_q, state_d;
  logic            outst_q, outst_d;       // a byte is with the UART
  logic [YW-1:0]   sent_cnt_q, sent_cnt_d; // data bytes acknowledged
  logic            trmt_q, trmt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic            frm_done_q, frm_done_d;
`ifdef CNN_TX_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Packer state
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;   // bits accepted this frame
  logic [2:0]      sub_cnt_q, sub_cnt_d;   // bit position inside the byte
  logic [7:0]      shift_q, shift_d;       // partially filled byte
  logic            push_q, push_d;         // deferred FIFO push
  logic [7:0]      push_byte_q, push_byte_d;

  logic            bit_accept;
  logic [7:0]      packed_byte;

  // FIFO interface
  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  cnn_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (fifo_pop),
    .din   (push_byte_q),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Derived only from flops, so it is glitch-free and low during reset.
  assign bit_rdy = busy_q && (bit_cnt_q < BIT_END) &&
                   (fifo_count <= RDY_LIMIT) && !fifo_full;

  assign bit_accept = bit_vld && bit_rdy;

  // Current partial byte with the incoming bit dropped into its slot; the
  // bits above the slot are still zero from the previous clear.
  always_comb begin
    packed_byte = shift_q;
    packed_byte[sub_cnt_q] = bit_in;
  end

  always_comb begin
    state_d     = state_q;
    outst_d     = outst_q;
    sent_cnt_d  = sent_cnt_q;
    trmt_d      = 1'b0;
    tx_data_d   = tx_data_q;
    frm_done_d  = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    fifo_pop    = 1'b0;
`ifdef CNN_TX_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    // Packer: runs whenever a bit is accepted, independent of FSM state.
    if (bit_accept) begin
      bit_cnt_d = bit_cnt_q + BW'(1);
      sub_cnt_d = sub_cnt_q + 3'd1;
      shift_d   = packed_byte;
      if (sub_cnt_q == 3'd7 || bit_cnt_q == BIT_LAST) begin
        push_d      = 1'b1;
        push_byte_d = packed_byte;
        shift_d     = '0;
        sub_cnt_d   = '0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (frm_strt) begin
          state_d    = S_HDR;
          bit_cnt_d  = '0;
          sub_cnt_d  = '0;
          shift_d    = '0;
          sent_cnt_d = '0;
`ifdef CNN_TX_CHECKSUM_EN
          csum_d     = '0;
`endif
          trmt_d     = 1'b1;
          tx_data_d  = HDR_BYTE;
          outst_d    = 1'b1;
        end
      end

      S_HDR: begin
        if (outst_q && tx_done) begin
          outst_d = 1'b0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (outst_q) begin
          if (tx_done) begin
            outst_d    = 1'b0;
            sent_cnt_d = sent_cnt_q + YW'(1);
            if (sent_cnt_q == BYTE_LAST) begin
`ifdef CNN_TX_CHECKSUM_EN
              // The sum already covers every popped byte, so the checksum
              // can be launched straight away.
              state_d   = S_CSUM;
              trmt_d    = 1'b1;
              tx_data_d = csum_q;
              outst_d   = 1'b1;
`else
              state_d   = S_DONE;
`endif
            end
          end
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          tx_data_d = fifo_dout;
          trmt_d    = 1'b1;
          outst_d   = 1'b1;
`ifdef CNN_TX_CHECKSUM_EN
          csum_d    = csum_q + fifo_dout;
`endif
        end
      end

`ifdef CNN_TX_CHECKSUM_EN
      S_CSUM: begin
        if (outst_q && tx_done) begin
          outst_d = 1'b0;
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        frm_done_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      outst_q     <= 1'b0;
      sent_cnt_q  <= '0;
      trmt_q      <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      frm_done_q  <= 1'b0;
      bit_cnt_q   <= '0;
      sub_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
`ifdef CNN_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      outst_q     <= outst_d;
      sent_cnt_q  <= sent_cnt_d;
      trmt_q      <= trmt_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      frm_done_q  <= frm_done_d;
      bit_cnt_q   <= bit_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
`ifdef CNN_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign trmt     = trmt_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign frm_done = frm_done_q;

endmodule

// File: doc/cnn_result_tx.md
CNN_RESULT_TX -- requirements
Module: cnn_result_tx

Interface
REQ-001 Parameters SHALL be:
- N_BITS, 676: result bits per frame (26x26).
- FIFO_DEPTH, 16: byte FIFO entries, power of 2.
- HDR_BYTE, 8'hA5: frame header byte.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- frm_strt, in, 1: start-frame pulse.
- bit_vld, in, 1: result bit valid.
- bit_in, in, 1: result bit.
- bit_rdy, out, 1: bit accepted when bit_vld and bit_rdy are both high.
- trmt, out, 1: UART transmit pulse.
- tx_data, out, 8: UART byte.
- tx_done, in, 1: UART byte finished.
- busy, out, 1: frame in progress.
- frm_done, out, 1: one-cycle end-of-frame pulse.

Function
REQ-003 N_BYTES SHALL be ceil(N_BITS/8); 85 at the default.
REQ-004 Packer: the k-th accepted bit of a byte SHALL go to byte bit k (LSB first); the 3-bit counter wraps 7->0.
REQ-005 A byte SHALL be pushed to the FIFO the cycle after its 8th bit, or after frame bit N_BITS-1; unfilled upper bits SHALL be 0.
REQ-006 bit_rdy SHALL be high only when all of these hold: busy; bits accepted < N_BITS; FIFO count <= FIFO_DEPTH-2. No byte SHALL ever be dropped.
REQ-007 The FSM SHALL have states IDLE, HDR, DATA, CSUM, DONE.
REQ-008 IDLE: on frm_strt, clear the bit, byte and checksum counters and go to HDR; frm_strt in any other state SHALL be ignored.
REQ-009 HDR: pulse trmt once with tx_data=HDR_BYTE; on tx_done go to DATA.
REQ-010 DATA: when the FIFO is non-empty and no byte is outstanding, pop, load tx_data and pulse trmt. After the tx_done of byte N_BYTES, go to CSUM (macro defined) or DONE.
REQ-011 CSUM: send the 8-bit modulo-256 sum of all data bytes (header excluded); on tx_done go to DONE.
REQ-012 DONE: frm_done=1 for one cycle, then IDLE.
REQ-013 trmt SHALL be a single-cycle pulse.
REQ-014 tx_data SHALL be held stable from trmt until tx_done.
REQ-015 The next trmt SHALL come no earlier than the cycle after tx_done; tx_done outside an outstanding byte SHALL be ignored.
REQ-016 Simultaneous FIFO push and pop SHALL leave the count unchanged; pop on empty SHALL never occur.
REQ-017 busy SHALL be 1 in every state except IDLE.

Reset
REQ-018 On rst_n low, at any point including mid-frame: state=IDLE; trmt=0, tx_data=0, busy=0, frm_done=0, bit_rdy=0; FIFO empty; all counters and the checksum cleared.
REQ-019 The first frame after reset release SHALL behave identically to a frame after power-up.

Configuration
REQ-020 Macro CNN_TX_CHECKSUM_EN:
- Defined: CSUM is implemented; a frame is N_BYTES+2 bytes.
- Undefined: the checksum logic and CSUM are removed; DATA goes directly to DONE; a frame is N_BYTES+1 bytes.

Structure
REQ-021 Package cnn_pkg SHALL hold:
- typedef tx_state_t.
- Constants CNN_HDR_BYTE=8'hA5 and CNN_RES_BITS=676.
REQ-022 The FIFO SHALL be a sub-module cnn_byte_fifo:
- Single clock, parameterised depth.
- Ports: push, pop, din, dout, count, empty, full.

Verification
REQ-023 Directed scenarios:
- All-1s, 676 bits, macro defined -> bytes A5, 84 x FF, 0F, BB; frm_done once.
- Alternating 1,0 starting with 1 -> A5, 84 x 55, 05, E9.
- bit_vld held high, tx_done delayed 200 cycles per byte -> bit_rdy drops at FIFO count 15; no byte lost; payload matches scenario 1.
- rst_n low after 100 bits -> trmt 0 and busy 0 immediately; the next frame is bit-exact with scenario 1.
- frm_strt pulsed mid-DATA -> ignored; exactly one header in the frame.
- Macro undefined, all-1s -> 86 bytes ending 0F; frm_done the cycle after the final tx_done plus one.
